de_pipe_reg: RTL and testbench
==============================

Name: de_pipe_reg

Overview:
- D→E pipeline register of the P5 five-stage MIPS core.
- Latches the decoded instruction, operands and control-unit outputs at each clock edge.
- Inserts a bubble when the hazard unit raises `stall` or when `flush` is asserted.
- Drives the E-stage hazard-tracking signals (E_Tnew, E_a3, E_we) back to the control unit, and keeps a saturating count of stall bubbles for performance debug.

Parameters:
- PC_RESET, 32'h0000_3000, value loaded into E_pc on reset.
- CNT_W, 16, width of the stall-bubble counter.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- stall  in  1  hazard stall from the control unit; insert bubble
- flush  in  1  kill the D-stage instruction; insert bubble
- D_instr  in  32  D-stage instruction word
- D_pc  in  32  D-stage PC
- D_rs_data  in  32  forwarded rs value
- D_rt_data  in  32  forwarded rt value
- D_ext  in  32  extended immediate
- a3_sel  in  2  destination select: 0=rt, 1=rd, 2=$31, 3=none
- RegWE  in  1  register write enable
- MemWE  in  1  memory write enable
- useImm  in  1  ALU B-operand select
- ALUop  in  4  ALU operation
- WBHop  in  2  load/store width op
- wd_sel  in  2  writeback source: 0=mem, 1=alu, 2=pc+8
- Tnew  in  2  cycles until result is produced, counted from E
- E_instr  out  32  latched instruction
- E_pc  out  32  latched PC
- E_pc8  out  32  E_pc + 8, the link value
- E_rs_data  out  32  latched rs value
- E_rt_data  out  32  latched rt value
- E_ext  out  32  latched immediate
- E_a3  out  5  resolved destination register
- E_we  out  1  effective register write
- E_MemWE  out  1  latched memory write enable
- E_useImm  out  1  latched B-operand select
- E_ALUop  out  4  latched ALU operation
- E_WBHop  out  2  latched width op
- E_wd_sel  out  2  latched writeback source
- E_Tnew  out  2  latched Tnew
- E_valid  out  1  1 = real instruction, 0 = bubble
- bubble_cnt  out  CNT_W  saturating count of stall bubbles

Behaviour:
- All state updates on the rising edge of clk; no combinational path from inputs to registered outputs.
- E_pc8 is combinational: E_pc + 32'd8, wrapping modulo 2^32.
- **Reset** (reset_n=0 at an edge), takes priority over everything:
  - every output register = 0, except E_pc = PC_RESET;
  - E_valid = 0; bubble_cnt = 0.
- **Bubble** (reset_n=1 and (stall | flush)):
  - E_instr, E_rs_data, E_rt_data, E_ext = 0;
  - all control outputs = 0: E_a3, E_we, E_MemWE, E_useImm, E_ALUop, E_WBHop, E_wd_sel, E_Tnew;
  - E_valid = 0; E_pc = D_pc, retained for later exception EPC use.
- **Normal** (reset_n=1, stall=0, flush=0): latch every D-side input.
  - E_a3 from a3_sel: 0→D_instr[20:16], 1→D_instr[15:11], 2→5'd31, 3→5'd0.
  - E_we = RegWE && (resolved a3 != 0).
  - E_valid = 1.
- The E_we qualification guarantees the hazard unit never stalls on $0.
- **bubble_cnt**:
  - increments by 1 on each non-reset edge with stall=1, whether or not flush is also 1;
  - saturates at all-ones and holds;
  - flush alone does not count.
- **Simultaneous stall and flush**: a single bubble is inserted, and the counter increments.
- **Stall held N cycles**: N consecutive bubbles; the D-stage instruction enters E on the first edge after stall falls. D-stage holding is the responsibility of the F/D register and PC.
- **Reset mid-stall**: reset wins; the counter clears; the first post-reset edge with stall=1 counts 1.
- Block-level state: none beyond the registers; no FSM beyond the valid/bubble state and the counter.

Test Plan:
- Reset: reset_n=0 for 2 edges → E_pc=32'h3000, E_pc8=32'h3008, all other outputs 0, E_valid=0, bubble_cnt=0.
- Normal add: D_instr=32'h0109_5020 (add $10,$8,$9), a3_sel=1, RegWE=1, Tnew=1, D_pc=32'h3004 → next edge: E_a3=10, E_we=1, E_Tnew=1, E_valid=1, E_pc8=32'h300C.
- jal: a3_sel=2, wd_sel=2, Tnew=2, RegWE=1 → E_a3=31, E_we=1. Then a write to $0 (a3_sel=0, instr rt=0, RegWE=1) → E_a3=0, E_we=0.
- Stall for 3 cycles with lw data valid → 3 edges with E_valid=0, E_Tnew=0, E_we=0, E_pc=D_pc; bubble_cnt=3. Next edge with stall=0 → instruction latched, E_valid=1.
- stall=1 and flush=1 together → one bubble, bubble_cnt+1. Then flush alone → bubble, bubble_cnt unchanged.
- Saturation with CNT_W=4: 20 stall cycles → bubble_cnt=4'hF. Then reset_n=0 mid-stall → bubble_cnt=0; next stall edge → bubble_cnt=1.

Source files
------------

// File: rtl/de_pipe_reg_if.sv
// rtl/de_pipe_reg_if.sv - D->E pipeline register bus: D-side inputs, hazard controls, E-side outputs
interface de_pipe_reg_if #(
    parameter int CNT_W = 16
);
    logic             stall;
    logic             flush;
    logic [31:0]      D_instr;
    logic [31:0]      D_pc;
    logic [31:0]      D_rs_data;
    logic [31:0]      D_rt_data;
    logic [31:0]      D_ext;
    logic [1:0]       a3_sel;
    logic             RegWE;
    logic             MemWE;
    logic             useImm;
    logic [3:0]       ALUop;
    logic [1:0]       WBHop;
    logic [1:0]       wd_sel;
    logic [1:0]       Tnew;

    logic [31:0]      E_instr;
    logic [31:0]      E_pc;
    logic [31:0]      E_pc8;
    logic [31:0]      E_rs_data;
    logic [31:0]      E_rt_data;
    logic [31:0]      E_ext;
    logic [4:0]       E_a3;
    logic             E_we;
    logic             E_MemWE;
    logic             E_useImm;
    logic [3:0]       E_ALUop;
    logic [1:0]       E_WBHop;
    logic [1:0]       E_wd_sel;
    logic [1:0]       E_Tnew;
    logic             E_valid;
    logic [CNT_W-1:0] bubble_cnt;

    modport master (
        output stall, flush, D_instr, D_pc, D_rs_data, D_rt_data, D_ext,
               a3_sel, RegWE, MemWE, useImm, ALUop, WBHop, wd_sel, Tnew,
        input  E_instr, E_pc, E_pc8, E_rs_data, E_rt_data, E_ext, E_a3, E_we,
               E_MemWE, E_useImm, E_ALUop, E_WBHop, E_wd_sel, E_Tnew, E_valid,
               bubble_cnt
    );

    modport slave (
        input  stall, flush, D_instr, D_pc, D_rs_data, D_rt_data, D_ext,
               a3_sel, RegWE, MemWE, useImm, ALUop, WBHop, wd_sel, Tnew,
        output E_instr, E_pc, E_pc8, E_rs_data, E_rt_data, E_ext, E_a3, E_we,
               E_MemWE, E_useImm, E_ALUop, E_WBHop, E_wd_sel, E_Tnew, E_valid,
               bubble_cnt
    );
endinterface

// File: rtl/de_pipe_reg.sv
// rtl/de_pipe_reg.sv - D->E pipeline register with bubble insertion and saturating stall counter
module de_pipe_reg #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int          CNT_W    = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    de_pipe_reg_if.slave bus
);
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      rs_q, rs_d;
    logic [31:0]      rt_q, rt_d;
    logic [31:0]      ext_q, ext_d;
    logic [4:0]       a3_q, a3_d;
    logic             we_q, we_d;
    logic             memwe_q, memwe_d;
    logic             useimm_q, useimm_d;
    logic [3:0]       aluop_q, aluop_d;
    logic [1:0]       wbhop_q, wbhop_d;
    logic [1:0]       wdsel_q, wdsel_d;
    logic [1:0]       tnew_q, tnew_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             bubble;
    logic [4:0]       a3_res;

    assign bubble = bus.stall | bus.flush;

    always_comb begin
        a3_res = 5'd0;
        case (bus.a3_sel)
            2'd0:    a3_res = bus.D_instr[20:16];
            2'd1:    a3_res = bus.D_instr[15:11];
            2'd2:    a3_res = 5'd31;
            default: a3_res = 5'd0;
        endcase
    end

    always_comb begin
        // Bubble defaults; PC still follows D so a later exception can report its EPC.
        instr_d  = 32'd0;
        pc_d     = bus.D_pc;
        rs_d     = 32'd0;
        rt_d     = 32'd0;
        ext_d    = 32'd0;
        a3_d     = 5'd0;
        we_d     = 1'b0;
        memwe_d  = 1'b0;
        useimm_d = 1'b0;
        aluop_d  = 4'd0;
        wbhop_d  = 2'd0;
        wdsel_d  = 2'd0;
        tnew_d   = 2'd0;
        valid_d  = 1'b0;
        if (!bubble) begin
            instr_d  = bus.D_instr;
            rs_d     = bus.D_rs_data;
            rt_d     = bus.D_rt_data;
            ext_d    = bus.D_ext;
            a3_d     = a3_res;
            // Writes to $0 are dropped so the hazard unit never stalls on it.
            we_d     = bus.RegWE && (a3_res != 5'd0);
            memwe_d  = bus.MemWE;
            useimm_d = bus.useImm;
            aluop_d  = bus.ALUop;
            wbhop_d  = bus.WBHop;
            wdsel_d  = bus.wd_sel;
            tnew_d   = bus.Tnew;
            valid_d  = 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (bus.stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            instr_q  <= 32'd0;
            pc_q     <= PC_RESET;
            rs_q     <= 32'd0;
            rt_q     <= 32'd0;
            ext_q    <= 32'd0;
            a3_q     <= 5'd0;
            we_q     <= 1'b0;
            memwe_q  <= 1'b0;
            useimm_q <= 1'b0;
            aluop_q  <= 4'd0;
            wbhop_q  <= 2'd0;
            wdsel_q  <= 2'd0;
            tnew_q   <= 2'd0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            instr_q  <= instr_d;
            pc_q     <= pc_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            ext_q    <= ext_d;
            a3_q     <= a3_d;
            we_q     <= we_d;
            memwe_q  <= memwe_d;
            useimm_q <= useimm_d;
            aluop_q  <= aluop_d;
            wbhop_q  <= wbhop_d;
            wdsel_q  <= wdsel_d;
            tnew_q   <= tnew_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.E_instr    = instr_q;
    assign bus.E_pc       = pc_q;
    assign bus.E_pc8      = pc_q + 32'd8;
    assign bus.E_rs_data  = rs_q;
    assign bus.E_rt_data  = rt_q;
    assign bus.E_ext      = ext_q;
    assign bus.E_a3       = a3_q;
    assign bus.E_we       = we_q;
    assign bus.E_MemWE    = memwe_q;
    assign bus.E_useImm   = useimm_q;
    assign bus.E_ALUop    = aluop_q;
    assign bus.E_WBHop    = wbhop_q;
    assign bus.E_wd_sel   = wdsel_q;
    assign bus.E_Tnew     = tnew_q;
    assign bus.E_valid    = valid_q;
    assign bus.bubble_cnt = cnt_q;
endmodule

// File: tb/tb_de_pipe_reg.sv
// tb/tb_de_pipe_reg.sv - randomized self-checking bench for de_pipe_reg against a behavioural model
module tb_de_pipe_reg;
    localparam int          CNT_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [31:0] PC_RST  = 32'h0000_3000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    de_pipe_reg_if #(.CNT_W(CNT_W)) bus();

    de_pipe_reg #(.PC_RESET(PC_RST), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] m_instr, m_pc, m_rs, m_rt, m_ext;
    logic [4:0]  m_a3;
    logic        m_we, m_memwe, m_useimm, m_valid;
    logic [3:0]  m_aluop;
    logic [1:0]  m_wbhop, m_wdsel, m_tnew;
    int          m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".instr"},  bus.E_instr,   m_instr);
        check({tag, ".pc"},     bus.E_pc,      m_pc);
        check({tag, ".pc8"},    bus.E_pc8,     m_pc + 32'd8);
        check({tag, ".rs"},     bus.E_rs_data, m_rs);
        check({tag, ".rt"},     bus.E_rt_data, m_rt);
        check({tag, ".ext"},    bus.E_ext,     m_ext);
        check({tag, ".a3"},     32'(bus.E_a3),       32'(m_a3));
        check({tag, ".we"},     32'(bus.E_we),       32'(m_we));
        check({tag, ".memwe"},  32'(bus.E_MemWE),    32'(m_memwe));
        check({tag, ".useimm"}, 32'(bus.E_useImm),   32'(m_useimm));
        check({tag, ".aluop"},  32'(bus.E_ALUop),    32'(m_aluop));
        check({tag, ".wbhop"},  32'(bus.E_WBHop),    32'(m_wbhop));
        check({tag, ".wdsel"},  32'(bus.E_wd_sel),   32'(m_wdsel));
        check({tag, ".tnew"},   32'(bus.E_Tnew),     32'(m_tnew));
        check({tag, ".valid"},  32'(bus.E_valid),    32'(m_valid));
        check({tag, ".cnt"},    32'(bus.bubble_cnt), 32'(m_cnt));
    endtask

    task automatic apply(input string tag, input logic rn, input logic st, input logic fl,
                         input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] ext,
                         input logic [1:0] a3s, input logic rwe, input logic mwe,
                         input logic uimm, input logic [3:0] aluop, input logic [1:0] wbh,
                         input logic [1:0] wds, input logic [1:0] tnew);
        logic [4:0] dest [4];
        @(negedge clk);
        reset_n = rn;
        bus.stall = st;       bus.flush = fl;
        bus.D_instr = instr;  bus.D_pc = pc;
        bus.D_rs_data = rs;   bus.D_rt_data = rt;   bus.D_ext = ext;
        bus.a3_sel = a3s;     bus.RegWE = rwe;      bus.MemWE = mwe;
        bus.useImm = uimm;    bus.ALUop = aluop;    bus.WBHop = wbh;
        bus.wd_sel = wds;     bus.Tnew = tnew;
        @(posedge clk);
        dest[0] = instr[20:16];
        dest[1] = instr[15:11];
        dest[2] = 5'd31;
        dest[3] = 5'd0;
        if (!rn) begin
            {m_instr, m_rs, m_rt, m_ext} = '0;
            m_pc = PC_RST;
            {m_a3, m_we, m_memwe, m_useimm, m_aluop, m_wbhop, m_wdsel, m_tnew, m_valid} = '0;
            m_cnt = 0;
        end else begin
            if (st || fl) begin
                {m_instr, m_rs, m_rt, m_ext} = '0;
                {m_a3, m_we, m_memwe, m_useimm, m_aluop, m_wbhop, m_wdsel, m_tnew, m_valid} = '0;
            end else begin
                m_instr = instr; m_rs = rs; m_rt = rt; m_ext = ext;
                m_a3 = dest[a3s];
                m_we = rwe && (m_a3 != 0);
                m_memwe = mwe; m_useimm = uimm; m_aluop = aluop;
                m_wbhop = wbh; m_wdsel = wds; m_tnew = tnew;
                m_valid = 1'b1;
            end
            m_pc = pc;
            if (st) m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
        end
        #1;
        check_all(tag);
    endtask

    task automatic step(input string tag, input logic rn, input logic st, input logic fl);
        apply(tag, rn, st, fl, $urandom, $urandom, $urandom, $urandom, $urandom,
              2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
              2'($urandom), 2'($urandom), 2'($urandom));
    endtask

    initial begin
        step("rst0", 1'b0, 1'b0, 1'b0);
        step("rst1", 1'b0, 1'b1, 1'b0);
        check("rst_pc",  bus.E_pc,  32'h0000_3000);
        check("rst_pc8", bus.E_pc8, 32'h0000_3008);

        apply("add", 1, 0, 0, 32'h0109_5020, 32'h3004, 32'd5, 32'd7, 32'd0,
              2'd1, 1, 0, 0, 4'd1, 2'd0, 2'd1, 2'd1);
        check("add_a3",  32'(bus.E_a3), 32'd10);
        check("add_pc8", bus.E_pc8, 32'h0000_300C);

        apply("jal", 1, 0, 0, 32'h0C00_0C00, 32'h3008, 32'd0, 32'd0, 32'd0,
              2'd2, 1, 0, 0, 4'd0, 2'd0, 2'd2, 2'd2);
        check("jal_a3", 32'(bus.E_a3), 32'd31);

        apply("wr0", 1, 0, 0, 32'h8C00_0000, 32'h300C, 32'd0, 32'd0, 32'd0,
              2'd0, 1, 0, 1, 4'd0, 2'd0, 2'd0, 2'd2);
        check("wr0_we", 32'(bus.E_we), 32'd0);

        for (int i = 0; i < 3; i++)
            apply("stall", 1, 1, 0, 32'h8D09_0004, 32'h3010, 32'd1, 32'd2, 32'd4,
                  2'd0, 1, 0, 1, 4'd0, 2'd0, 2'd0, 2'd2);
        check("stall_cnt", 32'(bus.bubble_cnt), 32'd3);
        apply("unstall", 1, 0, 0, 32'h8D09_0004, 32'h3010, 32'd1, 32'd2, 32'd4,
              2'd0, 1, 0, 1, 4'd0, 2'd0, 2'd0, 2'd2);
        check("unstall_valid", 32'(bus.E_valid), 32'd1);

        step("stfl", 1, 1, 1);
        check("stfl_cnt", 32'(bus.bubble_cnt), 32'd4);
        step("flush", 1, 0, 1);
        check("flush_cnt", 32'(bus.bubble_cnt), 32'd4);

        for (int i = 0; i < 20; i++) step("sat", 1, 1, 0);
        check("sat_cnt", 32'(bus.bubble_cnt), 32'hF);
        step("rst_mid", 0, 1, 0);
        check("rst_mid_cnt", 32'(bus.bubble_cnt), 32'd0);
        step("post_rst", 1, 1, 0);
        check("post_rst_cnt", 32'(bus.bubble_cnt), 32'd1);

        for (int i = 0; i < 400; i++)
            step("rand", ($urandom_range(31, 0) != 0), ($urandom_range(3, 0) == 0),
                 ($urandom_range(7, 0) == 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
